// File: rtl/uut_run_monitor_if.sv
// ---------------------------------------------------------------------------
// uut_run_monitor_if
// Job handshake between the autotest FSM (master) and uut_run_monitor (slave).
//   start      FSM -> mon  job request, sampled only while the monitor is idle
//   encdec_i   FSM -> mon  1=encrypt, 0=decrypt
//   block_i    FSM -> mon  input block
//   key_i      FSM -> mon  key
//   res_ack    FSM -> mon  result consumed
//   busy       mon -> FSM  monitor is not idle
//   res_valid  mon -> FSM  result fields valid, held until res_ack
//   res_block  mon -> FSM  latched UUT output block
//   key_cycles mon -> FSM  cycles from UUT reset release to key schedule done
//   run_cycles mon -> FSM  cycles from UUT reset release to enc/dec done
//   timeout    mon -> FSM  job aborted on the cycle limit
// ---------------------------------------------------------------------------
interface uut_run_monitor_if #(
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 80,
    parameter int CNT_W   = 32
);
    logic               start;
    logic               encdec_i;
    logic [BLOCK_W-1:0] block_i;
    logic [KEY_W-1:0]   key_i;
    logic               res_ack;
    logic               busy;
    logic               res_valid;
    logic [BLOCK_W-1:0] res_block;
    logic [CNT_W-1:0]   key_cycles;
    logic [CNT_W-1:0]   run_cycles;
    logic               timeout;

    modport master (
        output start, encdec_i, block_i, key_i, res_ack,
        input  busy, res_valid, res_block, key_cycles, run_cycles, timeout
    );

    modport slave (
        input  start, encdec_i, block_i, key_i, res_ack,
        output busy, res_valid, res_block, key_cycles, run_cycles, timeout
    );
endinterface

// File: rtl/uut_run_monitor.sv
// ---------------------------------------------------------------------------
// uut_run_monitor
// Runs one PRESENT enc/dec job per request: pulses the UUT reset, drives
// block/key/encdec, waits for key schedule and enc/dec done, then latches the
// result block and both cycle counts for the autotest FSM.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   job             uut_run_monitor_if.slave, FSM-side job handshake
//   rst_uut         active-high UUT reset (high whenever no job is running)
//   block_uut       UUT block input  (stable for the whole job)
//   key_uut         UUT key input    (stable for the whole job)
//   encdec_uut      UUT mode input   (stable for the whole job)
//   block_o_uut     UUT result block
//   end_key_uut     UUT key schedule done (level)
//   end_enc_uut     UUT encryption done (level)
//   end_dec_uut     UUT decryption done (level)
//
// Configuration
//   UUT_TIMEOUT_EN  when defined, a job that is not done while the run counter
//                   equals TIMEOUT-1 is aborted with timeout=1, res_block=0 and
//                   run_cycles=TIMEOUT. Undefined: the monitor waits forever.
// ---------------------------------------------------------------------------
module uut_run_monitor #(
    parameter int BLOCK_W    = 64,
    parameter int KEY_W      = 80,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    uut_run_monitor_if.slave   job,
    output logic               rst_uut,
    output logic [BLOCK_W-1:0] block_uut,
    output logic [KEY_W-1:0]   key_uut,
    output logic               encdec_uut,
    input  logic [BLOCK_W-1:0] block_o_uut,
    input  logic               end_key_uut,
    input  logic               end_enc_uut,
    input  logic               end_dec_uut
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT_KEY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t           state;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] run_cnt;

    logic [CNT_W-1:0] cnt_inc;
    logic             done_now;
    logic             key_hit;
    logic             fin_ok;
    logic             fin_to;
    logic             to_hit;

`ifdef UUT_TIMEOUT_EN
    assign to_hit = (run_cnt == CNT_W'(TIMEOUT - 1));
`else
    // No cycle limit in this build: the comparison is always false.
    assign to_hit = (TIMEOUT < 0);
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value held, which would infer a latch.
    always_comb begin
        cnt_inc  = (run_cnt == {CNT_W{1'b1}}) ? run_cnt : run_cnt + 1'b1;
        // Only the flag matching the job direction counts as done.
        done_now = encdec_uut ? end_enc_uut : end_dec_uut;
        key_hit  = 1'b0;
        fin_ok   = 1'b0;
        fin_to   = 1'b0;
        if (state == S_WAIT_KEY) begin
            key_hit = end_key_uut;
            fin_ok  = end_key_uut && done_now;
        end else if (state == S_WAIT_DONE) begin
            fin_ok  = done_now;
        end
        if ((state == S_WAIT_KEY || state == S_WAIT_DONE) && !fin_ok) begin
            fin_to = to_hit;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            rst_cnt        <= '0;
            run_cnt        <= '0;
            rst_uut        <= 1'b1;
            block_uut      <= '0;
            key_uut        <= '0;
            encdec_uut     <= 1'b0;
            job.busy       <= 1'b0;
            job.res_valid  <= 1'b0;
            job.res_block  <= '0;
            job.key_cycles <= '0;
            job.run_cycles <= '0;
            job.timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job.start) begin
                        block_uut      <= job.block_i;
                        key_uut        <= job.key_i;
                        encdec_uut     <= job.encdec_i;
                        job.key_cycles <= '0;
                        job.run_cycles <= '0;
                        run_cnt        <= '0;
                        rst_cnt        <= RST_LAST;
                        job.busy       <= 1'b1;
                        state          <= S_RST;
                    end
                end

                S_RST: begin
                    if (rst_cnt == '0) begin
                        // First released cycle is counted as cycle 1.
                        rst_uut <= 1'b0;
                        run_cnt <= CNT_W'(1);
                        state   <= S_WAIT_KEY;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end

                S_WAIT_KEY, S_WAIT_DONE: begin
                    run_cnt <= cnt_inc;
                    if (key_hit) begin
                        job.key_cycles <= run_cnt;
                    end
                    if (fin_ok || fin_to) begin
                        rst_uut       <= 1'b1;
                        job.res_valid <= 1'b1;
                        state         <= S_DONE;
                        if (fin_ok) begin
                            job.res_block  <= block_o_uut;
                            job.run_cycles <= run_cnt;
                        end else begin
                            job.timeout    <= 1'b1;
                            job.res_block  <= '0;
                            job.run_cycles <= CNT_W'(TIMEOUT);
                        end
                    end else if (key_hit) begin
                        state <= S_WAIT_DONE;
                    end
                end

                S_DONE: begin
                    if (job.res_ack) begin
                        job.res_valid <= 1'b0;
                        job.timeout   <= 1'b0;
                        job.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uut_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_uut_run_monitor
// Drives directed and random jobs into uut_run_monitor with a behavioural
// PRESENT stand-in, and compares every output on every cycle against a
// schedule model: a job accepted at edge e releases the UUT reset for
// max(key_at, done_at) cycles starting at cycle e+RST_CYCLES, then holds the
// result until the acknowledge edge.
// ---------------------------------------------------------------------------
module tb_uut_run_monitor;

    localparam int BW  = 64;
    localparam int KW  = 80;
    localparam int CW  = 32;
    localparam int RC  = 4;
    localparam int TO  = 100;
    localparam int INF = 1 << 30;
    localparam logic [63:0] ENC_TWEAK = 64'hA5C3_0F96_5A3C_F069;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uut_run_monitor_if #(.BLOCK_W(BW), .KEY_W(KW), .CNT_W(CW)) job_if ();

    logic          rst_uut;
    logic [BW-1:0] block_uut;
    logic [KW-1:0] key_uut;
    logic          encdec_uut;
    logic [BW-1:0] block_o_uut;
    logic          end_key_uut;
    logic          end_enc_uut;
    logic          end_dec_uut;

    uut_run_monitor #(
        .BLOCK_W(BW), .KEY_W(KW), .CNT_W(CW), .RST_CYCLES(RC), .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job         (job_if),
        .rst_uut     (rst_uut),
        .block_uut   (block_uut),
        .key_uut     (key_uut),
        .encdec_uut  (encdec_uut),
        .block_o_uut (block_o_uut),
        .end_key_uut (end_key_uut),
        .end_enc_uut (end_enc_uut),
        .end_dec_uut (end_dec_uut)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in UUT result: depends on inputs and on how long it has run.
    function automatic logic [63:0] uut_fn(input logic [63:0] b, input logic [79:0] k, input logic e);
        return b ^ k[79:16] ^ (e ? ENC_TWEAK : 64'h0);
    endfunction

    // Stand-in UUT timing, set by the stimulus before each start.
    int key_at = INF;
    int enc_at = INF;
    int dec_at = INF;

    initial begin : uut_model
        int k;
        k = 0;
        end_key_uut = 1'b0;
        end_enc_uut = 1'b0;
        end_dec_uut = 1'b0;
        block_o_uut = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_uut !== 1'b0) k = 0;
            else k++;
            end_key_uut = (k != 0) && (k >= key_at);
            end_enc_uut = (k != 0) && (k >= enc_at);
            end_dec_uut = (k != 0) && (k >= dec_at);
            block_o_uut = (k == 0) ? '0 : (uut_fn(block_uut, key_uut, encdec_uut) ^ BW'(k));
        end
    end

    // Schedule model of the monitor.
    int            cyc = 0;
    bit            m_job = 1'b0;
    int            m_e = 0;
    int            m_f = INF;
    int            m_span = 0;
    int            m_kc = 0;
    int            m_rc = 0;
    bit            m_to = 1'b0;
    bit            m_enc = 1'b0;
    logic [BW-1:0] m_blk = '0;
    logic [KW-1:0] m_key = '0;
    logic [BW-1:0] m_res = '0;

    initial begin : ref_model
        int d;
        int r;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_job = 1'b0;
                m_f   = INF;
                m_enc = 1'b0;
                m_blk = '0;
                m_key = '0;
            end else if ((!m_job || (m_f != INF && cyc - 1 >= m_f)) && job_if.start) begin
                m_job = 1'b1;
                m_e   = cyc;
                m_f   = INF;
                m_enc = job_if.encdec_i;
                m_blk = job_if.block_i;
                m_key = job_if.key_i;
                d     = m_enc ? enc_at : dec_at;
                r     = (key_at > d) ? key_at : d;
                m_to  = 1'b0;
                m_span = r;
                m_kc  = key_at;
                m_rc  = r;
                m_res = uut_fn(m_blk, m_key, m_enc) ^ BW'(r);
`ifdef UUT_TIMEOUT_EN
                if (r >= TO) begin
                    m_to   = 1'b1;
                    m_span = TO - 1;
                    m_kc   = (key_at <= TO - 1) ? key_at : 0;
                    m_rc   = TO;
                    m_res  = '0;
                end
`endif
            end else if (m_job && m_f == INF && cyc - 1 >= m_e + RC + m_span && job_if.res_ack) begin
                m_f = cyc;
            end
        end
    end

    initial begin : compare
        bit rel_e;
        bit rv_e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_busy", job_if.busy, 0);
                check("rst_valid", job_if.res_valid, 0);
                check("rst_timeout", job_if.timeout, 0);
                check("rst_rst_uut", rst_uut, 1);
                check("rst_res_block", job_if.res_block, 0);
                check("rst_key_cycles", job_if.key_cycles, 0);
                check("rst_run_cycles", job_if.run_cycles, 0);
                check("rst_uut_regs", {encdec_uut, key_uut, block_uut}, 0);
            end else begin
                rel_e = m_job && cyc >= m_e + RC && cyc < m_e + RC + m_span;
                rv_e  = m_job && cyc >= m_e + RC + m_span && cyc < m_f;
                check("busy", job_if.busy, m_job && cyc < m_f);
                check("rst_uut", rst_uut, !rel_e);
                check("res_valid", job_if.res_valid, rv_e);
                check("timeout", job_if.timeout, rv_e && m_to);
                check("block_uut", block_uut, m_blk);
                check("key_uut", key_uut, m_key);
                check("encdec_uut", encdec_uut, m_enc);
                if (rv_e) begin
                    check("res_block", job_if.res_block, m_res);
                    check("key_cycles", job_if.key_cycles, m_kc);
                    check("run_cycles", job_if.run_cycles, m_rc);
                end
            end
        end
    end

    // Presents a job for one cycle; returns with the accept edge just passed.
    task automatic start_job(input bit e, input int k, input int en, input int de,
                             input logic [BW-1:0] b, input logic [KW-1:0] ky);
        @(posedge clk);
        #1;
        key_at = k;
        enc_at = en;
        dec_at = de;
        job_if.encdec_i = e;
        job_if.block_i  = b;
        job_if.key_i    = ky;
        job_if.start    = 1'b1;
        @(posedge clk);
        #1;
        job_if.start = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (job_if.res_valid === 1'b1);
        end
        if (!seen) check("wait_res_valid", 0, 1);
    endtask

    task automatic ack_result(input int delay);
        repeat (delay) @(posedge clk);
        @(posedge clk);
        #1 job_if.res_ack = 1'b1;
        @(posedge clk);
        #1 job_if.res_ack = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [BW-1:0] b;
        logic [KW-1:0] ky;
        job_if.start    = 1'b0;
        job_if.encdec_i = 1'b0;
        job_if.block_i  = '0;
        job_if.key_i    = '0;
        job_if.res_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Encrypt: key after 5, enc after 32; also pin the reset pulse.
        b  = 64'h0123_4567_89AB_CDEF;
        ky = 80'hFFEE_DDCC_BBAA_9988_7766;
        start_job(1'b1, 5, 32, INF, b, ky);
        check("busy_after_accept", job_if.busy, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uut_last_high", rst_uut, 1);
        @(posedge clk);
        @(negedge clk);
        check("rst_uut_falls", rst_uut, 0);
        wait_result(100);
        check("enc_key_cycles", job_if.key_cycles, 5);
        check("enc_run_cycles", job_if.run_cycles, 32);
        check("enc_res_block", job_if.res_block, uut_fn(b, ky, 1'b1) ^ 64'd32);
        repeat (4) @(negedge clk);
        check("enc_valid_held", job_if.res_valid, 1);
        ack_result(0);
        @(negedge clk);
        check("enc_valid_cleared", job_if.res_valid, 0);

        // Decrypt: end_enc at 10 is ignored, end_dec at 40.
        b  = 64'hDEAD_BEEF_0BAD_F00D;
        ky = 80'h0011_2233_4455_6677_8899;
        start_job(1'b0, 7, 10, 40, b, ky);
        wait_result(100);
        check("dec_key_cycles", job_if.key_cycles, 7);
        check("dec_run_cycles", job_if.run_cycles, 40);
        check("dec_res_block", job_if.res_block, uut_fn(b, ky, 1'b0) ^ 64'd40);

        // Back-pressure: start held in DONE must not launch a job.
        @(posedge clk);
        #1;
        key_at = 3; enc_at = 9; dec_at = INF;
        job_if.encdec_i = 1'b1;
        job_if.block_i  = 64'h1111_2222_3333_4444;
        job_if.key_i    = 80'h5555_6666_7777_8888_9999;
        job_if.start    = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_still_valid", job_if.res_valid, 1);
        check("bp_block_kept", block_uut, b);
        ack_result(0);
        @(posedge clk);
        #1 job_if.start = 1'b0;
        @(negedge clk);
        check("bp_new_job_block", block_uut, 64'h1111_2222_3333_4444);
        wait_result(100);
        check("bp_run_cycles", job_if.run_cycles, 9);
        ack_result(1);

        // Key schedule finishing after done: both counts equal.
        start_job(1'b1, 12, 8, INF, 64'hCAFE_0000_0000_BABE, 80'h1);
        wait_result(100);
        check("late_key_key_cycles", job_if.key_cycles, 12);
        check("late_key_run_cycles", job_if.run_cycles, 12);
        ack_result(2);

        // Async reset in WAIT_DONE: outputs return to reset values immediately.
        start_job(1'b0, 3, 5, 50, 64'h7777_0000_7777_0000, 80'h2);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("mid_rst_busy", job_if.busy, 0);
        check("mid_rst_rst_uut", rst_uut, 1);
        check("mid_rst_key_cycles", job_if.key_cycles, 0);
        check("mid_rst_block_uut", block_uut, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Random jobs.
        for (int j = 0; j < 12; j++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            b  = {$urandom, $urandom};
            ky = {16'($urandom), $urandom, $urandom};
            start_job(1'($urandom_range(0, 1)), $urandom_range(1, 20),
                      $urandom_range(1, 60), $urandom_range(1, 60), b, ky);
            wait_result(200);
            ack_result($urandom_range(0, 4));
        end

`ifdef UUT_TIMEOUT_EN
        // UUT never finishes: abort at the cycle limit.
        start_job(1'b1, 10, INF, INF, 64'hFFFF_0000_FFFF_0000, 80'h3);
        wait_result(300);
        check("to_timeout", job_if.timeout, 1);
        check("to_run_cycles", job_if.run_cycles, TO);
        check("to_res_block", job_if.res_block, 0);
        check("to_key_cycles", job_if.key_cycles, 10);
        ack_result(0);
        @(negedge clk);
        check("to_cleared", job_if.timeout, 0);
`else
        check("timeout_tied_low", job_if.timeout, 0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
